// File: rtl/alu_operand_stage.sv
// Operand issue stage ahead of the ALU: register file, bypass, op check and a
// two-entry in-order skid buffer with valid/ready on both sides.
module alu_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic             use_imm,
    input  logic [3:0]       op_in,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [3:0]       op,
    output logic             err_op,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
    } entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] regs [NREGS];
    entry_t          head;
    entry_t          skid;
    entry_t          new_entry;
    logic            accept;
    logic            op_legal;
    logic            load_head;
    logic            load_skid;
    logic            shift_skid;

    assign accept = in_valid && in_ready;
    assign a      = head.a;
    assign b      = head.b;
    assign op     = head.op;

    // Operand fetch with same-cycle write-back bypass; x0 always reads zero.
    always_comb begin
        new_entry = '0;
        op_legal  = 1'b0;
        if (rs1 != '0) begin
            new_entry.a = (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
        end
        if (use_imm) begin
            new_entry.b = imm;
        end else if (rs2 != '0) begin
            new_entry.b = (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
        end
        case (op_in)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
        new_entry.op = op_legal ? op_in : OP_ADD;
    end

    // Buffer occupancy control.
    always_comb begin
        state_nxt  = state;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && !out_ready) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (accept && out_ready) begin
                    load_head = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_nxt  = ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head) begin
                head <= new_entry;
            end else if (shift_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= new_entry;
            end
        end
    end

    // Write-back port; writes to x0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_op       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (accept && !op_legal) begin
                err_op <= 1'b1;
            end
            if (out_valid && !out_ready && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic, checked
// against a queue-based reference model (default instance and a 4-bit counter instance).
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        use_imm = 1'b0;
    logic [3:0]  op_in = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, err_op;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [15:0] stall_cycles;

    logic        s_in_ready, s_out_valid, s_err_op;
    logic [31:0] s_a, s_b;
    logic [3:0]  s_op;
    logic [3:0]  s_stall;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .op_in(op_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .op(op),
        .err_op(err_op), .stall_cycles(stall_cycles)
    );

    alu_operand_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .op_in(op_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .a(s_a), .b(s_b), .op(s_op),
        .err_op(s_err_op), .stall_cycles(s_stall)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mregs [32];
    int          mstall;
    int          mstall4;
    bit          merr;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] o);
        return (o == 4'b0000) || (o == 4'b1000) || (o == 4'b0111) || (o == 4'b0110);
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return mregs[r];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mstall  = 0;
        mstall4 = 0;
        merr    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk({tag, ".a"}, a, mq[0].a);
            chk({tag, ".b"}, b, mq[0].b);
            chk({tag, ".op"}, 32'(op), 32'(mq[0].op));
        end
        chk({tag, ".err_op"}, 32'(err_op), 32'(merr));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(mstall));
        chk({tag, ".stall4"}, 32'(s_stall), 32'(mstall4));
    endtask

    // One clock cycle: inputs are already set; model advances on the edge.
    task automatic tick(input string tag);
        ent_t e;
        bit   acc;
        acc  = in_valid && (mq.size() < 2);
        e.a  = rd(rs1);
        e.b  = use_imm ? imm : rd(rs2);
        e.op = legal(op_in) ? op_in : 4'b0000;
        @(posedge clk);
        if (mq.size() > 0 && !out_ready) begin
            if (mstall < 65535) mstall++;
            if (mstall4 < 15) mstall4++;
        end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(e);
            if (!legal(op_in)) merr = 1'b1;
        end
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_outputs("reset");
        chk("reset.a", a, 32'h0);
        chk("reset.b", b, 32'h0);
        chk("reset.op", 32'(op), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write x5, x6 then issue a sub on them
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h10; tick("wb5");
        wb_addr = 5'd6; wb_data = 32'h3; tick("wb6");
        wb_en = 1'b0;
        in_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6; op_in = 4'b1000; out_ready = 1'b1;
        tick("issue");
        in_valid = 1'b0;
        chk("issue.a_const", a, 32'h10);
        chk("issue.b_const", b, 32'h3);
        chk("issue.op_const", 32'(op), 32'h8);
        chk("issue.valid_const", 32'(out_valid), 32'h1);
        tick("drain0");

        // Same-cycle bypass, and x0 ignores a write-back
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
        in_valid = 1'b1; rs1 = 5'd7; op_in = 4'b0000;
        tick("byp7");
        chk("byp7.a_const", a, 32'hDEAD);
        wb_addr = 5'd0; wb_data = 32'hFF; rs1 = 5'd0;
        tick("byp0");
        chk("byp0.a_const", a, 32'h0);
        wb_en = 1'b0; in_valid = 1'b0;
        tick("drain1");

        // Backpressure: three back-to-back requests
        out_ready = 1'b0; in_valid = 1'b1; rs1 = 5'd5; use_imm = 1'b1; op_in = 4'b0110;
        imm = 32'h1; tick("bp1");
        chk("bp1.in_ready_const", 32'(in_ready), 32'h1);
        imm = 32'h2; tick("bp2");
        chk("bp2.in_ready_const", 32'(in_ready), 32'h0);
        imm = 32'h3; tick("bp3");
        chk("bp3.in_ready_const", 32'(in_ready), 32'h0);
        chk("bp3.b_first", b, 32'h1);
        out_ready = 1'b1; tick("rel1");
        chk("rel1.b_second", b, 32'h2);
        tick("rel2");
        chk("rel2.b_third", b, 32'h3);
        in_valid = 1'b0;
        tick("rel3");

        // Illegal op becomes add and sets sticky error
        in_valid = 1'b1; op_in = 4'b0101; imm = 32'h7;
        tick("ill");
        chk("ill.op_const", 32'(op), 32'h0);
        chk("ill.b_const", b, 32'h7);
        chk("ill.err_const", 32'(err_op), 32'h1);
        op_in = 4'b0111; tick("legal_after");
        chk("legal_after.err_const", 32'(err_op), 32'h1);
        in_valid = 1'b0; tick("drain2");

        // Asynchronous reset while the buffer holds two entries
        out_ready = 1'b0; in_valid = 1'b1; op_in = 4'b1000;
        tick("fill1");
        tick("fill2");
        chk("fill2.in_ready_const", 32'(in_ready), 32'h0);
        #1 rst = 1'b1;
        model_reset();
        #1 check_outputs("midrst");
        chk("midrst.valid_const", 32'(out_valid), 32'h0);
        chk("midrst.err_const", 32'(err_op), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; use_imm = 1'b0; rs1 = 5'd5; rs2 = 5'd6; out_ready = 1'b1;
        tick("postrst");
        chk("postrst.a_const", a, 32'h0);
        chk("postrst.b_const", b, 32'h0);
        in_valid = 1'b0; tick("drain3");

        // Counter saturation on the 4-bit instance
        in_valid = 1'b1; out_ready = 1'b0; tick("sat_fill");
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick("sat");
        chk("sat.stall4_const", 32'(s_stall), 32'd15);
        chk("sat.stall16_const", 32'(stall_cycles), 32'd20);
        out_ready = 1'b1; tick("sat_drain");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            imm       = $urandom;
            use_imm   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: op_in = 4'b0000;
                1: op_in = 4'b1000;
                2: op_in = 4'b0111;
                3: op_in = 4'b0110;
                default: op_in = 4'($urandom_range(0, 15));
            endcase
            wb_en   = ($urandom_range(0, 1) != 0);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
